// File: rtl/cmpacc_pkg.sv
// Shared constants and types for the compare-accumulate bitmap interface.
// The bitmap producer and the cmpacc consumer both agree on these shapes.
package cmpacc_pkg;

  localparam int CMP_ROWS  = 64;
  localparam int CMP_COLS  = 24;
  localparam int CMP_RES_W = 13;

  // Field masks for the cmpacc result word.
  localparam logic [CMP_RES_W-1:0] RES_COL = 13'h001f;  // [4:0]   column offset
  localparam logic [CMP_RES_W-1:0] RES_ROW = 13'h07e0;  // [10:5]  row offset
  localparam logic [CMP_RES_W-1:0] RES_FLG = 13'h1800;  // [12:11] flags

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ISSUE,
    WAIT
  } feeder_state_t;

endpackage

// File: rtl/feeder_watchdog.sv
// Saturating wait counter for the cmpacc handshake.
// armed gates stale done pulses; expired marks the last allowed wait cycle.
module feeder_watchdog #(
  parameter int TIMEOUT = 512
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic armed,
  output logic expired
);

  localparam int            W    = $clog2(TIMEOUT);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

  logic [W-1:0] wcnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (en && wcnt != LAST) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  assign armed   = (wcnt >= W'(2));
  assign expired = (wcnt == LAST);

endmodule

// File: rtl/bitmap_feeder.sv
// Assembles a ROWS x COLS glyph frame from a row stream, strobes it into
// cmpacc, and returns the captured result or a timeout indication.
module bitmap_feeder
  import cmpacc_pkg::*;
#(
  parameter int ROWS    = CMP_ROWS,
  parameter int COLS    = CMP_COLS,
  parameter int TIMEOUT = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLS-1:0]       row_data,
  input  logic                  row_valid,
  output logic                  row_ready,
  output logic [ROWS*COLS-1:0]  bitmap,
  output logic                  wren,
  input  logic [CMP_RES_W-1:0]  result,
  input  logic                  done,
  output logic [CMP_RES_W-1:0]  res_out,
  output logic                  res_valid,
  output logic                  timeout,
  output logic                  busy
);

  localparam int               ROW_W    = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  feeder_state_t    state, state_nxt;
  logic [ROW_W-1:0] row_cnt;
  logic [ROW_W-1:0] row_idx;
  logic             row_wr;
  logic             wd_clr, wd_en, armed, expired;
  logic             take_res, take_to;

  feeder_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .armed   (armed),
    .expired (expired)
  );

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    row_ready = 1'b0;
    row_wr    = 1'b0;
    wren      = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    take_res  = 1'b0;
    take_to   = 1'b0;
    busy      = (state != IDLE);
    row_idx   = (state == IDLE) ? '0 : row_cnt;
    case (state)
      IDLE: begin
        row_ready = 1'b1;
        if (row_valid) begin
          row_wr    = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        row_ready = 1'b1;
        if (row_valid) begin
          row_wr = 1'b1;
          if (row_cnt == LAST_ROW) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wren      = 1'b1;
        wd_clr    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        wd_en = 1'b1;
        // A qualified done takes priority over expiry in the same cycle.
        if (done && armed) begin
          take_res  = 1'b1;
          state_nxt = IDLE;
        end else if (expired) begin
          take_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      res_out   <= '0;
      res_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_valid <= take_res;
      timeout   <= take_to;
      if (take_res) res_out <= result;
      if (row_wr)   row_cnt <= (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
    end
  end

  // NOTE: the frame store is reset on purpose: bitmap must read as zero straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitmap <= '0;
    end else if (row_wr) begin
      bitmap[COLS*(ROWS-1-int'(row_idx)) +: COLS] <= row_data;
    end
  end

endmodule

// File: tb/tb_bitmap_feeder.sv
// Directed scoreboard bench for bitmap_feeder: the flow pushes expected results,
// a negedge monitor pops and compares whenever res_valid or timeout fires.
module tb_bitmap_feeder;

  localparam int ROWS    = 64;
  localparam int COLS    = 24;
  localparam int TIMEOUT = 512;
  localparam int W       = ROWS * COLS;
  localparam int NEVER   = 1 << 20;

  logic            clk;
  logic            rst_n;
  logic [COLS-1:0] row_data;
  logic            row_valid;
  logic            row_ready;
  logic [W-1:0]    bitmap;
  logic            wren;
  logic [12:0]     result;
  logic            done;
  logic [12:0]     res_out;
  logic            res_valid;
  logic            timeout;
  logic            busy;

  bitmap_feeder #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_data  (row_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .bitmap    (bitmap),
    .wren      (wren),
    .result    (result),
    .done      (done),
    .res_out   (res_out),
    .res_valid (res_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_to;
    logic [12:0] res;
  } exp_t;

  exp_t            sb[$];
  int              errors = 0;
  int              checks = 0;
  logic [12:0]     last_res = '0;
  logic [COLS-1:0] frame [ROWS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bits(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int r = 0; r < ROWS; r++) begin
        if (act[W-1-COLS*r -: COLS] !== exp[W-1-COLS*r -: COLS]) begin
          $display("FAIL %s: row %0d got %h expected %h", name, r,
                   act[W-1-COLS*r -: COLS], exp[W-1-COLS*r -: COLS]);
          break;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] pack_frame();
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) v[W-1-COLS*r -: COLS] = frame[r];
    return v;
  endfunction

  task automatic set_frame(input int kind);
    for (int r = 0; r < ROWS; r++) begin
      case (kind)
        0: frame[r] = (r < 4) ? 24'h3fffff : (r >= 36 && r <= 61) ? 24'h3f0000 : 24'h000000;
        1: frame[r] = 24'(r * 24'h010203) ^ 24'ha5a5a5;
        default: frame[r] = 24'h800001 | (24'h1 << (r % COLS));
      endcase
    end
  endtask

  // Monitor: pops one expectation per res_valid/timeout pulse.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && timeout) begin
      errors++; checks++;
      $display("FAIL pulse_overlap: res_valid and timeout both high");
    end
    if (res_valid || timeout) begin
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_pulse: res_valid=%b timeout=%b with empty scoreboard", res_valid, timeout);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_timeout", {31'd0, timeout}, {31'd0, e.is_to});
        check("res_out", {19'd0, res_out}, {19'd0, e.res});
      end
    end
  end

  // Caller is at a negedge. Returns at the negedge after the last accept.
  task automatic send_frame(input int n, input bit gaps);
    int idx = 0;
    int guard = 0;
    int early = 0;
    bit rdy_ok = 1'b1;
    bit busy_ok = 1'b1;
    while (idx < n && guard < 8 * ROWS) begin
      if (wren) early++;
      if (!row_ready) rdy_ok = 1'b0;
      if (idx > 0 && !busy) busy_ok = 1'b0;
      row_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      row_data  = frame[idx];
      if (row_valid && row_ready) idx++;
      @(negedge clk);
      guard++;
    end
    row_valid = 1'b0;
    check("rows_accepted", idx, n);
    check("row_ready_during_fill", {31'd0, rdy_ok}, 32'd1);
    check("busy_during_fill", {31'd0, busy_ok}, 32'd1);
    check("no_early_wren", early, 0);
  endtask

  // Caller is at the ISSUE negedge.
  task automatic check_issue();
    check("issue_wren", {31'd0, wren}, 32'd1);
    check("issue_row_ready", {31'd0, row_ready}, 32'd0);
    check("issue_busy", {31'd0, busy}, 32'd1);
    check_bits("issue_bitmap", bitmap, pack_frame());
  endtask

  // cmpacc model. d0/d1: done during wcnt 0/1 (d0 also covers ISSUE);
  // from wcnt 2 on, done is high once wcnt >= k.
  task automatic wait_phase(input bit d0, input bit d1, input int k, input logic [12:0] res);
    int ret = -1;
    int extra = 0;
    int exp_ret;
    if (k <= TIMEOUT - 1) begin
      sb.push_back('{1'b0, res});
      last_res = res;
      exp_ret  = k + 1;
    end else begin
      sb.push_back('{1'b1, last_res});
      exp_ret = TIMEOUT;
    end
    done   = d0;
    result = res;
    for (int j = 0; j <= TIMEOUT + 8; j++) begin
      @(negedge clk);
      if (wren) extra++;
      if (row_ready) begin
        ret = j;
        break;
      end
      done = (j == 0) ? d0 : (j == 1) ? d1 : (j >= k);
    end
    done = 1'b0;
    check("return_cycle", ret, exp_ret);
    check("single_wren", extra, 0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check_bits("bitmap_stable", bitmap, pack_frame());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    done      = 1'b0;
    result    = '0;
    repeat (2) @(negedge clk);
    check_bits("reset_bitmap", bitmap, '0);
    check("reset_wren", {31'd0, wren}, 32'd0);
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_res_out", {19'd0, res_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_row_ready", {31'd0, row_ready}, 32'd1);

    // Plan frame, no gaps, done at wcnt=5.
    set_frame(0);
    send_frame(ROWS, 1'b0);
    check_issue();
    check("top_row", {8'd0, bitmap[1535:1512]}, 32'h3fffff);
    check("bottom_row", {8'd0, bitmap[23:0]}, 32'h0);
    wait_phase(1'b0, 1'b0, 5, 13'h0042);

    // Stale done held into ISSUE and wcnt 0, dropped at 1, raised at 4.
    set_frame(1);
    done = 1'b1;
    send_frame(ROWS, 1'b0);
    check_issue();
    wait_phase(1'b1, 1'b0, 4, 13'h1fff);

    // Plan frame with random gaps; done never arrives.
    set_frame(0);
    send_frame(ROWS, 1'b1);
    check_issue();
    wait_phase(1'b0, 1'b0, NEVER, 13'h0aaa);

    // done coincides with the expiry cycle: done wins.
    set_frame(1);
    send_frame(ROWS, 1'b0);
    check_issue();
    wait_phase(1'b0, 1'b0, TIMEOUT - 1, 13'h0123);

    // Earliest qualified done, then a back-to-back frame in the res_valid cycle.
    set_frame(2);
    send_frame(ROWS, 1'b0);
    check_issue();
    wait_phase(1'b0, 1'b0, 2, 13'h0abc);
    check("b2b_res_valid", {31'd0, res_valid}, 32'd1);
    set_frame(0);
    send_frame(ROWS, 1'b0);
    check_issue();
    wait_phase(1'b0, 1'b0, 3, 13'h1555);

    // Asynchronous reset after 30 rows, then a full frame.
    set_frame(1);
    send_frame(30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_bits("midfill_reset_bitmap", bitmap, '0);
    check("midfill_reset_busy", {31'd0, busy}, 32'd0);
    check("midfill_reset_res_out", {19'd0, res_out}, 32'd0);
    check("midfill_reset_wren", {31'd0, wren}, 32'd0);
    last_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_row_ready", {31'd0, row_ready}, 32'd1);
    set_frame(2);
    send_frame(ROWS, 1'b0);
    check_issue();
    wait_phase(1'b0, 1'b0, 6, 13'h0777);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
